// File: rtl/entropy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : entropy_pkg
// Brief    : Shared FSM state encoding and FIFO pointer/occupancy widths
//            for the entropy stream packer.
// Revision : 1.0 - initial release
// ============================================================================
package entropy_pkg;

    localparam int unsigned c_default_fifo_depth = 16;
    localparam int unsigned c_default_ptr_w      = $clog2(c_default_fifo_depth);
    localparam int unsigned c_default_occ_w      = c_default_ptr_w + 1;

    localparam int unsigned c_state_w = 2;
    localparam logic [c_state_w-1:0] c_idle   = 2'd0;
    localparam logic [c_state_w-1:0] c_stream = 2'd1;
    localparam logic [c_state_w-1:0] c_drain  = 2'd2;

    // Pointer width for a power-of-two ring of 'depth' entries
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy must represent 0..depth inclusive, hence one extra bit
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/entropy_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : entropy_byte_fifo
// Brief    : Ring buffer accepting up to MAX_BYTES bytes per write and
//            returning one byte per read, with a registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module entropy_byte_fifo
    import entropy_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BYTES = 5,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 3,
    parameter int OCC_W     = occ_width(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [MAX_BYTES*WIDTH-1:0] wr_data,
    input  logic [CNT_WIDTH-1:0]       wr_count,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [OCC_W-1:0]           occupancy,
    output logic [OCC_W-1:0]           occupancy_next
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [OCC_W-1:0]     r_occ;
    logic [PTR_W-1:0]     w_wr_base;
    logic [CNT_WIDTH-1:0] w_wr_cnt;
    logic                 w_rd;

    // A clear restarts the ring at 0 so a same-cycle write lands at the front
    always_comb begin
        w_wr_cnt       = wr_en ? wr_count : '0;
        w_rd           = rd_en && (r_occ != '0) && !clear;
        w_wr_base      = clear ? '0 : r_tail;
        occupancy_next = (clear ? '0 : (r_occ - OCC_W'(w_rd))) + OCC_W'(w_wr_cnt);
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_head <= clear ? '0 : (r_head + PTR_W'(w_rd));
            r_tail <= w_wr_base + PTR_W'(w_wr_cnt);
            r_occ  <= occupancy_next;
        end
    end

    // Byte-lane writes; lane i goes to tail+i, wrapping mid-beat if needed
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (CNT_WIDTH'(i) < w_wr_cnt) begin
                r_mem[w_wr_base + PTR_W'(i)] <= wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Head byte, forced to zero when nothing is buffered
    always_comb begin
        rd_data   = (r_occ != '0) ? r_mem[r_head] : '0;
        occupancy = r_occ;
    end

endmodule
`default_nettype wire

// File: rtl/entropy_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : entropy_stream_packer
// Brief    : Packs variable-count byte beats into a single-byte output
//            stream with frame-last tracking. Optional statistics outputs
//            are enabled with the ENTROPY_PACKER_STATS_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module entropy_stream_packer
    import entropy_pkg::*;
#(
    parameter int TOP_BITSTREAM_WIDTH = 8,
    parameter int TOP_MAX_BYTES       = 5,
    parameter int TOP_FIFO_DEPTH      = 16,
    parameter int TOP_CNT_WIDTH       = 3
) (
    input  logic                                         top_clk,
    input  logic                                         top_reset,
    input  logic                                         top_flag_first,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [TOP_MAX_BYTES*TOP_BITSTREAM_WIDTH-1:0] in_bytes,
    input  logic [TOP_CNT_WIDTH-1:0]                     in_count,
    input  logic                                         in_last,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [TOP_BITSTREAM_WIDTH-1:0]               out_byte,
    output logic                                         out_last
`ifdef ENTROPY_PACKER_STATS_EN
    ,
    output logic [31:0]                                  out_total_bytes,
    output logic                                         out_overflow_err
`endif
);

    localparam int OCC_W = occ_width(TOP_FIFO_DEPTH);
    localparam logic [OCC_W-1:0]         c_ready_limit = OCC_W'(TOP_FIFO_DEPTH - TOP_MAX_BYTES);
    localparam logic [TOP_CNT_WIDTH-1:0] c_max_cnt     = TOP_CNT_WIDTH'(TOP_MAX_BYTES);

    logic [c_state_w-1:0]     r_state;
    logic [c_state_w-1:0]     w_state_next;
    logic [c_state_w-1:0]     w_state_base;
    logic [OCC_W-1:0]         w_occ;
    logic [OCC_W-1:0]         w_occ_next;
    logic [TOP_CNT_WIDTH-1:0] w_count;
    logic                     w_accept;
    logic                     w_pop;

    // Clamp illegal counts and form the two handshakes
    always_comb begin
        w_count  = (in_count > c_max_cnt) ? c_max_cnt : in_count;
        w_accept = in_valid && in_ready;
        w_pop    = out_valid && out_ready;
    end

    entropy_byte_fifo #(
        .WIDTH     (TOP_BITSTREAM_WIDTH),
        .MAX_BYTES (TOP_MAX_BYTES),
        .DEPTH     (TOP_FIFO_DEPTH),
        .CNT_WIDTH (TOP_CNT_WIDTH),
        .OCC_W     (OCC_W)
    ) u_fifo (
        .clk            (top_clk),
        .rst            (top_reset),
        .clear          (top_flag_first),
        .wr_en          (w_accept),
        .wr_data        (in_bytes),
        .wr_count       (w_count),
        .rd_en          (w_pop),
        .rd_data        (out_byte),
        .occupancy      (w_occ),
        .occupancy_next (w_occ_next)
    );

    // FSM state register
    always_ff @(posedge top_clk or posedge top_reset) begin
        if (top_reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; a frame-start clear restarts evaluation from IDLE
    always_comb begin
        w_state_base = top_flag_first ? c_idle : r_state;
        w_state_next = w_state_base;
        case (w_state_base)
            c_idle, c_stream: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_state_next = (w_occ_next == '0) ? c_idle : c_drain;
                    end else begin
                        w_state_next = c_stream;
                    end
                end
            end
            c_drain: begin
                if (w_occ_next == '0) begin
                    w_state_next = c_idle;
                end
            end
            default: w_state_next = c_idle;
        endcase
    end

    // FSM outputs; in_ready depends only on registered state and the clear
    always_comb begin
        in_ready  = !top_reset &&
                    (top_flag_first || ((r_state != c_drain) && (w_occ <= c_ready_limit)));
        out_valid = !top_reset && (w_occ != '0);
        out_last  = !top_reset && (r_state == c_drain) && (w_occ == OCC_W'(1));
    end

`ifdef ENTROPY_PACKER_STATS_EN
    logic [31:0] r_total_bytes;
    logic        r_overflow_err;

    // Popped-byte counter and sticky illegal-count flag; frame start clears both
    always_ff @(posedge top_clk or posedge top_reset) begin
        if (top_reset) begin
            r_total_bytes  <= '0;
            r_overflow_err <= 1'b0;
        end else if (top_flag_first) begin
            r_total_bytes  <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_total_bytes <= r_total_bytes + 32'd1;
            end
            if (in_valid && (in_count > c_max_cnt)) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    assign out_total_bytes  = r_total_bytes;
    assign out_overflow_err = r_overflow_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_entropy_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_entropy_stream_packer
// Brief    : Self-checking bench for entropy_stream_packer. A byte-queue
//            reference model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_entropy_stream_packer;

    localparam int W     = 8;
    localparam int MB    = 5;
    localparam int DEPTH = 16;
    localparam int CW    = 3;

    logic          top_clk = 1'b0;
    logic          top_reset;
    logic          top_flag_first;
    logic          in_valid;
    logic          in_ready;
    logic [MB*W-1:0] in_bytes;
    logic [CW-1:0] in_count;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_byte;
    logic          out_last;
`ifdef ENTROPY_PACKER_STATS_EN
    logic [31:0]   out_total_bytes;
    logic          out_overflow_err;
`endif

    entropy_stream_packer #(
        .TOP_BITSTREAM_WIDTH (W),
        .TOP_MAX_BYTES       (MB),
        .TOP_FIFO_DEPTH      (DEPTH),
        .TOP_CNT_WIDTH       (CW)
    ) dut (
        .top_clk          (top_clk),
        .top_reset        (top_reset),
        .top_flag_first   (top_flag_first),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_bytes         (in_bytes),
        .in_count         (in_count),
        .in_last          (in_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_byte         (out_byte),
        .out_last         (out_last)
`ifdef ENTROPY_PACKER_STATS_EN
        ,
        .out_total_bytes  (out_total_bytes),
        .out_overflow_err (out_overflow_err)
`endif
    );

    always #5 top_clk = ~top_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: buffered bytes in stream order, plus whether the
    // current frame has been closed and is waiting to empty.
    byte unsigned q[$];
    bit           m_draining = 1'b0;
    int unsigned  m_total    = 0;
    bit           m_ovf      = 1'b0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input bit exp_ready);
        logic [63:0] exp_byte;
        exp_byte = 64'd0;
        if (q.size() != 0) exp_byte = 64'(q[0]);
        check_value("in_ready",  in_ready,  exp_ready);
        check_value("out_valid", out_valid, q.size() != 0);
        check_value("out_byte",  out_byte,  exp_byte);
        check_value("out_last",  out_last,  m_draining && (q.size() == 1));
`ifdef ENTROPY_PACKER_STATS_EN
        check_value("total_bytes", out_total_bytes, m_total);
        check_value("overflow",    out_overflow_err, m_ovf);
`endif
    endtask

    // One clock cycle: drive at negedge, check before the edge, update model at the edge
    task automatic step(input bit v, input logic [MB*W-1:0] b, input int c,
                        input bit l, input bit ordy, input bit ff);
        bit exp_ready;
        bit acc;
        bit pop;
        int n;
        in_valid       = v;
        in_bytes       = b;
        in_count       = CW'(c);
        in_last        = l;
        out_ready      = ordy;
        top_flag_first = ff;
        #1;
        exp_ready = ff || (!m_draining && ((DEPTH - q.size()) >= MB));
        check_outputs(exp_ready);
        acc = v && exp_ready;
        pop = (q.size() != 0) && ordy;
        @(posedge top_clk);
        if (ff) begin
            q.delete();
            m_draining = 1'b0;
            m_total    = 0;
            m_ovf      = 1'b0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                m_total++;
            end
            if (v && (c > MB)) m_ovf = 1'b1;
        end
        if (acc) begin
            n = (c > MB) ? MB : c;
            for (int i = 0; i < n; i++) q.push_back(b[i*W +: W]);
            if (l) m_draining = (q.size() != 0);
        end
        if (m_draining && (q.size() == 0)) m_draining = 1'b0;
        @(negedge top_clk);
    endtask

    task automatic idle_steps(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 0, 1'b0, ordy, 1'b0);
    endtask

    function automatic logic [MB*W-1:0] rand_bytes();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[MB*W-1:0];
    endfunction

    // Reset; with check_now the outputs are checked while reset is held mid-cycle
    task automatic apply_reset(input bit check_now);
        top_reset      = 1'b1;
        in_valid       = 1'b0;
        top_flag_first = 1'b0;
        out_ready      = 1'b1;
        q.delete();
        m_draining = 1'b0;
        m_total    = 0;
        m_ovf      = 1'b0;
        #1;
        if (check_now) check_outputs(1'b0);
        @(posedge top_clk);
        @(negedge top_clk);
        check_outputs(1'b0);
        top_reset = 1'b0;
    endtask

    initial begin
        top_reset      = 1'b1;
        top_flag_first = 1'b0;
        in_valid       = 1'b0;
        in_bytes       = '0;
        in_count       = '0;
        in_last        = 1'b0;
        out_ready      = 1'b0;
        @(negedge top_clk);
        apply_reset(1'b0);

        // Single closed frame of five bytes
        step(1'b1, 40'h0504030201, 5, 1'b1, 1'b1, 1'b0);
        idle_steps(7, 1'b1);

        // Empty last beat on an empty buffer
        step(1'b1, rand_bytes(), 0, 1'b1, 1'b1, 1'b0);
        idle_steps(2, 1'b1);

        // Backpressure fill, then drain
        for (int i = 0; i < 5; i++) step(1'b1, rand_bytes(), 5, 1'b0, 1'b0, 1'b0);
        idle_steps(20, 1'b1);

        // Pointer wrap: move pointers to 14, then a 4-byte beat spans the wrap
        apply_reset(1'b0);
        step(1'b1, rand_bytes(), 5, 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_bytes(), 5, 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_bytes(), 4, 1'b0, 1'b0, 1'b0);
        idle_steps(16, 1'b1);
        step(1'b1, rand_bytes(), 4, 1'b1, 1'b1, 1'b0);
        idle_steps(6, 1'b1);

        // Frame-start clear with seven buffered bytes and a new two-byte beat
        apply_reset(1'b0);
        step(1'b1, rand_bytes(), 5, 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_bytes(), 2, 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_bytes(), 2, 1'b0, 1'b0, 1'b1);
        check_value("flag_occ", q.size(), 2);
        idle_steps(4, 1'b1);

`ifdef ENTROPY_PACKER_STATS_EN
        // Statistics: ten bytes popped, then an illegal count
        apply_reset(1'b0);
        step(1'b1, rand_bytes(), 5, 1'b0, 1'b1, 1'b0);
        step(1'b1, rand_bytes(), 5, 1'b1, 1'b1, 1'b0);
        idle_steps(12, 1'b1);
        step(1'b1, rand_bytes(), 7, 1'b0, 1'b0, 1'b0);
        idle_steps(3, 1'b0);
        check_value("stats_total10", out_total_bytes, 10);
        check_value("stats_ovf_held", out_overflow_err, 1);
`endif

        // Randomized traffic with a mid-frame reset
        apply_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2;
                apply_reset(1'b1);
            end
            step($urandom_range(0, 3) != 0, rand_bytes(), int'($urandom_range(0, 7)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/entropy_stream_packer.md
ENTROPY_STREAM_PACKER -- requirements
Module: entropy_stream_packer

Interface
REQ-001 SHALL have parameter TOP_BITSTREAM_WIDTH, default 8, bits per output byte.
REQ-002 SHALL have parameter TOP_MAX_BYTES, default 5, maximum bytes accepted per input beat.
REQ-003 SHALL have parameter TOP_FIFO_DEPTH, default 16, buffer entries; power of two, at least 2*TOP_MAX_BYTES.
REQ-004 SHALL have parameter TOP_CNT_WIDTH, default 3, width of in_count; at least clog2(TOP_MAX_BYTES+1).
REQ-005 SHALL have port top_clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port top_reset, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port top_flag_first, input, 1, synchronous frame-start clear.
REQ-008 SHALL have port in_valid, input, 1, input beat valid.
REQ-009 SHALL have port in_ready, output, 1, packer accepts a beat.
REQ-010 SHALL have port in_bytes, input, TOP_MAX_BYTES*TOP_BITSTREAM_WIDTH, byte 0 in the LSBs and first in stream order.
REQ-011 SHALL have port in_count, input, TOP_CNT_WIDTH, number of valid bytes, 0..TOP_MAX_BYTES.
REQ-012 SHALL have port in_last, input, 1, final beat of the frame.
REQ-013 SHALL have port out_valid, input-side counterpart output, 1, out_byte valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts out_byte.
REQ-015 SHALL have port out_byte, output, TOP_BITSTREAM_WIDTH, head of buffer.
REQ-016 SHALL have port out_last, output, 1, out_byte is the final byte of the frame.

Function
REQ-017 Accept SHALL occur when in_valid and in_ready are both high; it writes in_count bytes in order at the tail.
REQ-018 Pop SHALL occur when out_valid and out_ready are both high; it removes the head byte.
REQ-019 Accept and pop in the same cycle SHALL both take effect; occupancy_next = occupancy + accepted count - pop.
REQ-020 in_ready SHALL be high iff top_reset is low, state is not DRAIN, and free entries are at least TOP_MAX_BYTES; it is derived from registered state only.
REQ-021 out_valid SHALL be high iff occupancy is nonzero; out_byte SHALL be the head entry.
REQ-022 A byte accepted in cycle t SHALL be poppable no earlier than cycle t+1.
REQ-023 Head and tail pointers SHALL wrap modulo TOP_FIFO_DEPTH; a write of several bytes SHALL wrap mid-beat correctly.
REQ-024 in_count greater than TOP_MAX_BYTES is illegal; it SHALL be clamped to TOP_MAX_BYTES.
REQ-025 The FSM SHALL have states IDLE, STREAM and DRAIN.
REQ-026 IDLE SHALL go to STREAM on accept with in_last low.
REQ-027 IDLE or STREAM SHALL go to DRAIN on accept with in_last high.
REQ-028 DRAIN SHALL go to IDLE on the pop that empties the buffer.
REQ-029 If an accepted last beat leaves occupancy 0, the FSM SHALL go directly to IDLE and out_last SHALL never assert for that frame.
REQ-030 out_last SHALL be high iff state is DRAIN and occupancy equals 1.
REQ-031 top_flag_first high SHALL, on that clock edge, discard all buffered bytes, zero the pointers and force IDLE.
REQ-032 With top_flag_first high, in_ready SHALL be high; a simultaneous valid beat SHALL be written into the emptied buffer and drive the FSM as if from IDLE.

Reset
REQ-033 While top_reset is high, the block SHALL hold pointers 0, occupancy 0 and state IDLE.
REQ-034 While top_reset is high, out_valid, out_last and in_ready SHALL be 0; out_byte SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL drop all buffered data with no further out_valid.

Configuration
REQ-036 With macro ENTROPY_PACKER_STATS_EN defined, the block SHALL add output out_total_bytes (32 bits, bytes popped, wrapping) and output out_overflow_err (sticky).
REQ-037 out_overflow_err SHALL set on in_valid with in_count > TOP_MAX_BYTES.
REQ-038 top_reset and top_flag_first SHALL clear both statistics outputs.
REQ-039 Without ENTROPY_PACKER_STATS_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-040 The shared package entropy_pkg SHALL hold the FSM state encoding and the pointer/occupancy width localparams derived from TOP_FIFO_DEPTH.
REQ-041 Storage SHALL be one sub-module, entropy_byte_fifo: a multi-byte-write, single-byte-read ring buffer with a registered occupancy count; the FSM and handshakes SHALL remain in the top.

Verification
REQ-042 Scenario: after reset, one beat count=5, bytes 01..05, last=1, out_ready=1 -> out_byte 01,02,03,04,05 on consecutive cycles; out_last only with 05; in_ready 0 until IDLE.
REQ-043 Scenario: out_ready=0, beats count=5 repeatedly -> in_ready drops once occupancy exceeds 11 (DEPTH 16); no byte lost or duplicated after out_ready=1.
REQ-044 Scenario: pointers at 14, beat count=4 -> bytes land at 14,15,0,1 and pop in order.
REQ-045 Scenario: top_flag_first with occupancy 7 and a valid count=2 beat -> next cycle occupancy 2, head equals the new byte 0.
REQ-046 Scenario: last beat count=0 with empty buffer -> state IDLE next cycle, out_valid and out_last stay 0.
REQ-047 Scenario: with ENTROPY_PACKER_STATS_EN, 10 bytes popped plus one count=7 beat -> out_total_bytes=10, out_overflow_err=1 and held.
